// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle of serial_sub_ctrl. Define SERIAL_SUB_OVF_EN to add the ovf flag.
interface serial_sub_ctrl_if #(parameter int WIDTH = serial_sub_pkg::WIDTH_DEF);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor, LSB first, one bit per cycle through a single full_sub cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  serial_sub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             borrow_q, bout_q;
  logic             dbit, bnext, last;

  full_sub u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (borrow_q),
    .d_o    (dbit),
    .bout_o (bnext)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
  end

  // res_q doubles as the visible diff; it only moves between an accepted start and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      cnt_q    <= '0;
      a_q      <= bus.a;
      b_q      <= bus.b;
      borrow_q <= bus.bin;
    end else if (state_q == SHIFT) begin
      cnt_q    <= cnt_q + 1'b1;
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      res_q    <= {dbit, res_q[WIDTH-1:1]};
      borrow_q <= bnext;
      if (last) bout_q <= bnext;
    end
  end

  assign bus.diff = res_q;
  assign bus.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last cycle borrow_q is the borrow into the MSB stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_q <= 1'b0;
    else if (state_q == SHIFT && last) ovf_q <= borrow_q ^ bnext;
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed + random bench for serial_sub_ctrl with a scoreboard of expected results.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    int   ux, uy, sx, sy, r;
    ux = int'(x); uy = int'(y);
    sx = $signed(x); sy = $signed(y);
    r  = sx - sy - int'(c);
    e.d  = W'(ux - uy - int'(c));
    e.bo = (ux - uy - int'(c)) < 0;
    e.ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return e;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(bus.diff), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("diff", 64'(bus.diff), 64'(e.d));
        chk("bout", 64'(bus.bout), 64'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 64'(bus.ovf), 64'(e.ov));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 64) begin tick(); n++; end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    exp_t e;
    int   n;
    e = model(ta, tb_, tbin);
    exp_q.push_back(e);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.bin = tbin;
    tick();
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    chk("busy_in_shift", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("latency", 64'(n), 64'(W + 1));
    tick();
    chk("done_single", 64'(bus.done), 64'd0);
    chk("diff_hold", 64'(bus.diff), 64'(e.d));
    chk("bout_hold", 64'(bus.bout), 64'(e.bo));
  endtask

  initial begin
    int   n, nd0, c0, gap;
    int   stamps[$];
    exp_t e;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    #2;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_bout", 64'(bus.bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    // start pulse during the 3rd SHIFT cycle must be ignored
    nd0 = n_done;
    exp_q.push_back(model(8'h09, 8'h04, 1'b0));
    bus.start = 1'b1; bus.a = 8'h09; bus.b = 8'h04; bus.bin = 1'b0;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h00;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    repeat (W + 4) tick();
    chk("ignored_start_dones", 64'(n_done - nd0), 64'd1);
    chk("ignored_start_queue", 64'(exp_q.size()), 64'd0);
    chk("ignored_start_idle", 64'(bus.busy), 64'd0);

    // reset in the 4th SHIFT cycle aborts without done
    nd0 = n_done;
    exp_q.push_back(model(8'h33, 8'h11, 1'b0));
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_diff", 64'(bus.diff), 64'd0);
    chk("abort_bout", 64'(bus.bout), 64'd0);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    repeat (W + 4) tick();
    chk("abort_no_done", 64'(n_done - nd0), 64'd0);
    run_op(8'hAA, 8'h55, 1'b0);

    // start held high: one op every W+2 cycles
    nd0 = n_done;
    e = model(8'h3C, 8'h5A, 1'b1);
    repeat (3) exp_q.push_back(e);
    bus.start = 1'b1; bus.a = 8'h3C; bus.b = 8'h5A; bus.bin = 1'b1;
    c0 = 0;
    while (stamps.size() < 3 && c0 < 100) begin
      tick(); c0++;
      if (bus.done) begin
        stamps.push_back(c0);
        if (stamps.size() == 3) bus.start = 1'b0;
      end
    end
    chk("b2b_count", 64'(stamps.size()), 64'd3);
    for (int i = 1; i < stamps.size(); i++) begin
      gap = stamps[i] - stamps[i-1];
      chk("b2b_period", 64'(gap), 64'(W + 2));
    end
    repeat (W + 4) tick();
    chk("b2b_dones", 64'(n_done - nd0), 64'd3);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
